ebus_arb_mux: RTL

Parametrised, registered EBUS source multiplexer and arbiter. Sits at top level between the per-module XXX_EBUS/XXXdrivingEBUS outputs (EDP, IR, SCD, APR, CRA, and later RH20/DTE20) and the shared EBUS/EBUS_DS consumed by the EBOX. It adds the following to the plain priority mux:
- selectable fixed-priority or round-robin arbitration
- idle-hold or idle-zero policy
- owner reporting
- sticky multi-driver conflict detection
- a no-responder timeout on diagnostic EBUS reads

---
 rtl/ebus_pkg.sv | 24 ++
 rtl/ebus_arb_pick.sv | 53 +++++
 rtl/ebus_arb_mux.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ebus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ebus_pkg
// Purpose  : Shared EBUS widths, source indices and slice-offset helper.
// Revision : 1.0
// ============================================================================
package ebus_pkg;

    localparam int EBUS_WIDTH    = 36;
    localparam int EBUS_DS_WIDTH = 8;

    localparam int SRC_EDP = 0;
    localparam int SRC_IR  = 1;
    localparam int SRC_SCD = 2;
    localparam int SRC_APR = 3;
    localparam int SRC_CRA = 4;

    // Base bit of source idx within the flattened srcData vector.
    function automatic int sliceOffset(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ebus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ebus_arb_pick
// Purpose  : Combinational EBUS winner selection (fixed priority or round-robin).
// Revision : 1.0
// ============================================================================
module ebus_arb_pick
    import ebus_pkg::*;
#(
    parameter  int NSRC = 8,
    parameter  int RR   = 0,
    localparam int IDXW = $clog2(NSRC)
) (
    input  logic [0:NSRC-1] srcDriving,
    input  logic [IDXW-1:0] rrPtr,
    output logic [IDXW-1:0] winner,
    output logic            anyDriving,
    output logic            multiDriving
);

    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_lowAll;
    logic [IDXW-1:0] w_lowMasked;
    logic            w_anyMasked;
    logic [4:0]      w_count;

    // Fixed priority is round-robin with the search origin pinned at 0.
    assign w_start = (RR != 0) ? rrPtr : '0;

    always_comb begin
        w_lowAll     = '0;
        w_lowMasked  = '0;
        w_anyMasked  = 1'b0;
        w_count      = '0;
        anyDriving   = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (srcDriving[i]) begin
                anyDriving = 1'b1;
                w_lowAll   = IDXW'(i);
                w_count    = w_count + 5'd1;
                if (i >= int'(w_start)) begin
                    w_anyMasked = 1'b1;
                    w_lowMasked = IDXW'(i);
                end
            end
        end
        // Nothing at/after the origin means the circular search wrapped.
        winner       = w_anyMasked ? w_lowMasked : w_lowAll;
        multiDriving = (w_count > 5'd1);
    end

endmodule
`default_nettype wire

// File: rtl/ebus_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : ebus_arb_mux
// Purpose  : Registered EBUS source mux/arbiter with conflict and timeout flags.
// Revision : 1.0
// ============================================================================
module ebus_arb_mux
    import ebus_pkg::*;
#(
    parameter  int NSRC      = 8,
    parameter  int WIDTH     = EBUS_WIDTH,
    parameter  int DSW       = EBUS_DS_WIDTH,
    parameter  int RR        = 0,
    parameter  int HOLD_IDLE = 1,
    parameter  int TIMEOUT   = 15,
    localparam int IDXW      = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [0:NSRC-1]       srcDriving,
    input  logic [0:NSRC*WIDTH-1] srcData,
    input  logic [0:DSW-1]        dsIn,
    input  logic                  dsReq,
    input  logic                  clrErr,
    output logic [0:WIDTH-1]      EBUS,
    output logic [0:DSW-1]        EBUS_DS,
    output logic                  busValid,
    output logic [IDXW-1:0]       busOwner,
    output logic                  conflictErr,
    output logic                  timeoutErr
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    logic [IDXW-1:0]  w_winner;
    logic             w_any;
    logic             w_multi;
    logic [0:WIDTH-1] w_selData;
    logic [7:0]       w_timerNext;
    logic             w_waiting;
    logic             w_timeoutHit;

    logic [0:WIDTH-1] r_ebus;
    logic [0:DSW-1]   r_ebusDs;
    logic             r_busValid;
    logic [IDXW-1:0]  r_busOwner;
    logic             r_conflict;
    logic             r_timeout;
    logic [IDXW-1:0]  r_rrPtr;
    logic [7:0]       r_timer;

    ebus_arb_pick #(
        .NSRC (NSRC),
        .RR   (RR)
    ) u_pick (
        .srcDriving   (srcDriving),
        .rrPtr        (r_rrPtr),
        .winner       (w_winner),
        .anyDriving   (w_any),
        .multiDriving (w_multi)
    );

    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (w_winner == IDXW'(k)) begin
                w_selData = srcData[sliceOffset(k, WIDTH) +: WIDTH];
            end
        end
    end

    assign w_waiting    = dsReq && !w_any;
    assign w_timerNext  = r_timer + 8'd1;
    assign w_timeoutHit = w_waiting && (w_timerNext == c_timeout);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ebus     <= '0;
            r_ebusDs   <= '0;
            r_busValid <= 1'b0;
            r_busOwner <= '0;
            r_conflict <= 1'b0;
            r_timeout  <= 1'b0;
            r_rrPtr    <= '0;
            r_timer    <= '0;
        end else begin
            r_ebusDs   <= dsIn;
            r_busValid <= w_any;

            if (w_any) begin
                r_ebus     <= w_selData;
                r_busOwner <= w_winner;
                r_rrPtr    <= (w_winner == IDXW'(NSRC - 1)) ? '0 : w_winner + 1'b1;
            end else if (w_timeoutHit || (HOLD_IDLE == 0)) begin
                r_ebus <= '0;
            end

            if (!w_waiting || w_timeoutHit) begin
                r_timer <= '0;
            end else begin
                r_timer <= w_timerNext;
            end

            // A set condition in the same cycle as clrErr takes precedence.
            if (w_multi) begin
                r_conflict <= 1'b1;
            end else if (clrErr) begin
                r_conflict <= 1'b0;
            end

            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end else if (clrErr) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign EBUS        = r_ebus;
    assign EBUS_DS     = r_ebusDs;
    assign busValid    = r_busValid;
    assign busOwner    = r_busOwner;
    assign conflictErr = r_conflict;
    assign timeoutErr  = r_timeout;

endmodule
`default_nettype wire
